// File: rtl/execute_stage_mc.sv
// Parametrised integer execute stage: N-source bypass, load-use interlock, iterative
// multiply (and divide when EXEC_DIV_EN is defined), synchronous flush.
module execute_stage_mc #(
    parameter int XLEN       = 32,
    parameter int NUM_BYPASS = 2,
    parameter int REG_W      = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_stall,
    input  logic [3:0]                  in_op,
    input  logic [REG_W-1:0]            in_rs1,
    input  logic [REG_W-1:0]            in_rs2,
    input  logic [REG_W-1:0]            in_rd,
    input  logic [XLEN-1:0]             in_rs1_val,
    input  logic [XLEN-1:0]             in_rs2_val,
    input  logic [XLEN-1:0]             in_imm,
    input  logic                        in_imm_valid,
    input  logic                        in_is_ld,
    input  logic [NUM_BYPASS-1:0]       byp_valid,
    input  logic [NUM_BYPASS*REG_W-1:0] byp_reg,
    input  logic [NUM_BYPASS*XLEN-1:0]  byp_val,
    output logic                        out_valid,
    output logic [REG_W-1:0]            out_rd,
    output logic [XLEN-1:0]             out_val,
    output logic [XLEN-1:0]             out_rs2_val,
    output logic                        out_is_ld,
    output logic                        out_illegal
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_MUL, OP_MULHU, OP_DIVU, OP_REMU
    } op_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   s1, s2, rs2_fwd, alu_val;
    logic [SH_W-1:0]   shamt;
    logic              is_mc, illegal, hazard, accept;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, mc_next;
    logic [XLEN-1:0]   opnd, mc_rs2, mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [REG_W-1:0]  mc_rd;
    logic              mc_hi;
`ifdef EXEC_DIV_EN
    logic              mc_div, div_ge;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
`endif

    // Out stage beats every bypass entry; lower bypass index beats higher.
    function automatic logic [XLEN-1:0] resolve(input logic [REG_W-1:0] idx,
                                                input logic [XLEN-1:0]  rf_val);
        logic [XLEN-1:0] val;
        logic            hit;
        val = rf_val;
        hit = 1'b0;
        if (idx == '0) begin
            val = '0;
            hit = 1'b1;
        end else if (out_valid && !out_is_ld && out_rd == idx) begin
            val = out_val;
            hit = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_BYPASS; i++) begin
            if (!hit && byp_valid[i] && byp_reg[i*REG_W +: REG_W] == idx) begin
                val = byp_val[i*XLEN +: XLEN];
                hit = 1'b1;
            end
        end
        return val;
    endfunction

    always_comb begin
        s1      = resolve(in_rs1, in_rs1_val);
        rs2_fwd = resolve(in_rs2, in_rs2_val);
        s2      = in_imm_valid ? in_imm : rs2_fwd;
        shamt   = s2[SH_W-1:0];
    end

    always_comb begin
        alu_val = '0;
        is_mc   = 1'b0;
        illegal = 1'b0;
        case (in_op)
            OP_ADD:           alu_val = s1 + s2;
            OP_SUB:           alu_val = s1 - s2;
            OP_AND:           alu_val = s1 & s2;
            OP_OR:            alu_val = s1 | s2;
            OP_XOR:           alu_val = s1 ^ s2;
            OP_SLL:           alu_val = s1 << shamt;
            OP_SRL:           alu_val = s1 >> shamt;
            OP_SRA:           alu_val = $unsigned($signed(s1) >>> shamt);
            OP_MUL, OP_MULHU: is_mc = 1'b1;
`ifdef EXEC_DIV_EN
            OP_DIVU, OP_REMU: is_mc = 1'b1;
`endif
            default:          illegal = 1'b1;
        endcase
        if (in_is_ld && !illegal) alu_val = s1 + s2;
    end

    // rs2 only counts toward the hazard when it actually feeds s2.
    assign hazard = (state == IDLE) && in_valid && out_valid && out_is_ld && (out_rd != '0) &&
                    ((out_rd == in_rs1) || (!in_imm_valid && out_rd == in_rs2));
    assign accept = (state == IDLE) && in_valid && !flush && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_stall   = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    in_stall = hazard;
                    if (accept && is_mc) state_next = BUSY;
                end
                BUSY: begin
                    in_stall = 1'b1;
                    if (cnt == '0) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_addend = acc[0] ? opnd : '0;
        mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        mc_next    = {mul_sum, acc[XLEN-1:1]};
`ifdef EXEC_DIV_EN
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[XLEN-1:0] - opnd;
        if (mc_div)
            mc_next = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            out_is_ld   <= 1'b0;
            out_rd      <= '0;
            out_val     <= '0;
            out_rs2_val <= '0;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            mc_rs2      <= '0;
            mc_rd       <= '0;
            mc_hi       <= 1'b0;
`ifdef EXEC_DIV_EN
            mc_div      <= 1'b0;
`endif
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            out_is_ld   <= 1'b0;
            cnt         <= '0;
        end else if (state == BUSY) begin
            if (cnt == '0) begin
                out_valid   <= 1'b1;
                out_illegal <= 1'b0;
                out_is_ld   <= 1'b0;
                out_rd      <= mc_rd;
                out_val     <= mc_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
                out_rs2_val <= mc_rs2;
            end else begin
                acc <= mc_next;
                cnt <= cnt - 1'b1;
            end
        end else if (accept && !is_mc) begin
            out_valid   <= 1'b1;
            out_illegal <= illegal;
            out_is_ld   <= in_is_ld;
            out_rd      <= in_rd;
            out_val     <= alu_val;
            out_rs2_val <= rs2_fwd;
        end else begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            out_is_ld   <= 1'b0;
            if (accept) begin
                cnt    <= CNT_W'(XLEN);
                mc_rd  <= in_rd;
                mc_rs2 <= rs2_fwd;
                mc_hi  <= in_op[0];
`ifdef EXEC_DIV_EN
                mc_div <= in_op[1];
                acc    <= in_op[1] ? {{XLEN{1'b0}}, s1} : {{XLEN{1'b0}}, s2};
                opnd   <= in_op[1] ? s2 : s1;
`else
                acc    <= {{XLEN{1'b0}}, s2};
                opnd   <= s1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: expected results queued at issue, compared on out_valid.
module tb_execute_stage_mc;
    localparam int XLEN = 32;
    localparam int NB   = 2;
    localparam int RW   = 5;

    logic             clk;
    logic             rst_n, flush, in_valid, in_stall;
    logic [3:0]       in_op;
    logic [RW-1:0]    in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0]  in_rs1_val, in_rs2_val, in_imm;
    logic             in_imm_valid, in_is_ld;
    logic [NB-1:0]    byp_valid;
    logic [NB*RW-1:0] byp_reg;
    logic [NB*XLEN-1:0] byp_val;
    logic             out_valid, out_is_ld, out_illegal;
    logic [RW-1:0]    out_rd;
    logic [XLEN-1:0]  out_val, out_rs2_val;

    execute_stage_mc #(.XLEN(XLEN), .NUM_BYPASS(NB), .REG_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_stall(in_stall),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_imm_valid(in_imm_valid), .in_is_ld(in_is_ld), .byp_valid(byp_valid),
        .byp_reg(byp_reg), .byp_val(byp_val), .out_valid(out_valid), .out_rd(out_rd),
        .out_val(out_val), .out_rs2_val(out_rs2_val), .out_is_ld(out_is_ld),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [RW-1:0] rd;
        logic [XLEN-1:0] val;
        logic [XLEN-1:0] rs2;
        logic          ld;
        logic          ill;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   next_id  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [RW-1:0] rd, input logic [XLEN-1:0] val,
                        input logic [XLEN-1:0] rs2, input logic ld, input logic ill);
        exp_t e;
        e.id = next_id; e.rd = rd; e.val = val; e.rs2 = rs2; e.ld = ld; e.ill = ill;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("out_rd#%0d", e.id), out_rd, e.rd);
                chk($sformatf("out_val#%0d", e.id), out_val, e.val);
                chk($sformatf("out_rs2_val#%0d", e.id), out_rs2_val, e.rs2);
                chk($sformatf("out_is_ld#%0d", e.id), out_is_ld, e.ld);
                chk($sformatf("out_illegal#%0d", e.id), out_illegal, e.ill);
            end
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic [RW-1:0] rd, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                         input logic [XLEN-1:0] imm, input logic immv, input logic ld);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_imm_valid = immv; in_is_ld = ld;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Call right after the accepting tick; waits for the queued result within a cycle budget.
    task automatic run_mc(input string tag, input int exp_lat);
        int n = 0;
        int stall_low = 0;
        idle();
        while (sb.size() != 0 && n < 100) begin
            if (!in_stall) stall_low++;
            tick();
            n++;
        end
        chk({tag, "_pending"}, sb.size(), 0);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_stall_low_cycles"}, stall_low, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_rd = '0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_imm_valid = 1'b0;
        in_is_ld = 1'b0; byp_valid = '0; byp_reg = '0; byp_val = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_in_stall", in_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD, then SUB through the out-stage bypass, then wrapping SUB
        push(5'd3, 32'd12, 32'd0, 0, 0);
        issue(4'd0, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'd7, 1, 0);
        tick();
        push(5'd4, 32'd7, 32'd5, 0, 0);
        issue(4'd1, 5'd3, 5'd1, 5'd4, 32'hDEAD, 32'd5, 32'd0, 0, 0);
        tick();
        push(5'd6, 32'hFFFF_FFFF, 32'd1, 0, 0);
        issue(4'd1, 5'd0, 5'd7, 5'd6, 32'd0, 32'd1, 32'd0, 0, 0);
        tick();

        // Bypass priority: byp[0] over byp[1]; out stage over byp; r0 stays zero
        push(5'd8, 32'hAA, 32'hAA, 0, 0);
        issue(4'd3, 5'd2, 5'd2, 5'd8, 32'h11, 32'h11, 32'd0, 0, 0);
        byp_valid = 2'b11; byp_reg = {5'd2, 5'd2}; byp_val = {32'hBB, 32'hAA};
        tick();
        push(5'd10, 32'hAB, 32'd0, 0, 0);
        issue(4'd0, 5'd8, 5'd0, 5'd10, 32'h0, 32'h0, 32'd1, 1, 0);
        byp_valid = 2'b01; byp_reg = {5'd0, 5'd8}; byp_val = {32'h0, 32'h99};
        tick();
        push(5'd9, 32'd3, 32'd0, 0, 0);
        issue(4'd0, 5'd0, 5'd0, 5'd9, 32'h77, 32'h0, 32'd3, 1, 0);
        byp_valid = 2'b01; byp_reg = {5'd0, 5'd0}; byp_val = {32'h0, 32'h55};
        tick();

        // Shifts (amount masked to 5 bits), logic ops, illegal opcode
        push(5'd16, 32'h8000_0000, 32'd0, 0, 0);
        issue(4'd5, 5'd1, 5'd0, 5'd16, 32'd1, 32'd0, 32'h3F, 1, 0);
        byp_valid = '0;
        tick();
        push(5'd17, 32'h0800_0000, 32'd0, 0, 0);
        issue(4'd6, 5'd1, 5'd0, 5'd17, 32'h8000_0000, 32'd0, 32'd4, 1, 0);
        tick();
        push(5'd18, 32'hF800_0000, 32'd0, 0, 0);
        issue(4'd7, 5'd1, 5'd0, 5'd18, 32'h8000_0000, 32'd0, 32'd4, 1, 0);
        tick();
        push(5'd19, 32'h0FF0, 32'hFF00, 0, 0);
        issue(4'd4, 5'd1, 5'd2, 5'd19, 32'hF0F0, 32'hFF00, 32'd0, 0, 0);
        tick();
        push(5'd20, 32'hF000, 32'hFF00, 0, 0);
        issue(4'd2, 5'd1, 5'd2, 5'd20, 32'hF0F0, 32'hFF00, 32'd0, 0, 0);
        tick();
        push(5'd21, 32'd0, 32'h33, 0, 1);
        issue(4'd12, 5'd1, 5'd2, 5'd21, 32'h5, 32'h33, 32'd0, 0, 0);
        tick();

        // Load-use: one stall cycle with a bubble, then the load data arrives on byp[0]
        push(5'd5, 32'h44, 32'd0, 1, 0);
        issue(4'd0, 5'd1, 5'd0, 5'd5, 32'h40, 32'd0, 32'd4, 1, 1);
        tick();
        issue(4'd0, 5'd5, 5'd0, 5'd11, 32'd0, 32'd0, 32'h10, 1, 0);
        #1;
        chk("lu_stall", in_stall, 1);
        tick();
        chk("lu_bubble", out_valid, 0);
        @(negedge clk);
        byp_valid = 2'b01; byp_reg = {5'd0, 5'd5}; byp_val = {32'h0, 32'h100};
        #1;
        chk("lu_stall_release", in_stall, 0);
        push(5'd11, 32'h110, 32'd0, 0, 0);
        tick();
        chk("lu_pending", sb.size(), 0);
        @(negedge clk);
        byp_valid = '0;

        // Iterative multiply
        push(5'd12, 32'd42, 32'd6, 0, 0);
        issue(4'd8, 5'd1, 5'd2, 5'd12, 32'd7, 32'd6, 32'd0, 0, 0);
        tick();
        chk("mul_accept_valid", out_valid, 0);
        run_mc("mul", XLEN + 1);
        push(5'd13, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0);
        issue(4'd9, 5'd1, 5'd2, 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0);
        tick();
        run_mc("mulhu", XLEN + 1);

`ifdef EXEC_DIV_EN
        push(5'd22, 32'd14, 32'd7, 0, 0);
        issue(4'd10, 5'd1, 5'd2, 5'd22, 32'd100, 32'd7, 32'd0, 0, 0);
        tick();
        run_mc("divu", XLEN + 1);
        push(5'd23, 32'd2, 32'd7, 0, 0);
        issue(4'd11, 5'd1, 5'd2, 5'd23, 32'd100, 32'd7, 32'd0, 0, 0);
        tick();
        run_mc("remu", XLEN + 1);
        push(5'd24, 32'hFFFF_FFFF, 32'd0, 0, 0);
        issue(4'd10, 5'd1, 5'd2, 5'd24, 32'h1234, 32'd0, 32'd0, 0, 0);
        tick();
        run_mc("divu_by_zero", XLEN + 1);
        push(5'd25, 32'd9, 32'd0, 0, 0);
        issue(4'd11, 5'd1, 5'd2, 5'd25, 32'd9, 32'd0, 32'd0, 0, 0);
        tick();
        run_mc("remu_by_zero", XLEN + 1);
`else
        push(5'd22, 32'd0, 32'd7, 0, 1);
        issue(4'd10, 5'd1, 5'd2, 5'd22, 32'd100, 32'd7, 32'd0, 0, 0);
        tick();
        chk("divu_illegal_pending", sb.size(), 0);
        push(5'd23, 32'd0, 32'd7, 0, 1);
        issue(4'd11, 5'd1, 5'd2, 5'd23, 32'd100, 32'd7, 32'd0, 0, 0);
        tick();
        chk("remu_illegal_pending", sb.size(), 0);
`endif

        // Flush in the 10th busy cycle; the uop presented alongside flush is dropped
        issue(4'd8, 5'd1, 5'd2, 5'd13, 32'd3, 32'd4, 32'd0, 0, 0);
        tick();
        idle();
        for (int k = 0; k < 9; k++) tick();
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 4'd0; in_rs1 = 5'd1; in_rd = 5'd26; in_imm = 32'd1; in_imm_valid = 1'b1;
        #1;
        chk("flush_stall", in_stall, 0);
        tick();
        chk("flush_out_valid", out_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_flush_stall", in_stall, 0);
        for (int k = 0; k < 40; k++) tick();
        push(5'd14, 32'd5, 32'd9, 0, 0);
        issue(4'd0, 5'd1, 5'd2, 5'd14, 32'd2, 32'd9, 32'd3, 1, 0);
        tick();
        chk("post_flush_add_pending", sb.size(), 0);

        // Asynchronous reset while busy clears outputs immediately
        issue(4'd8, 5'd1, 5'd2, 5'd15, 32'd3, 32'd4, 32'd0, 0, 0);
        tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_rd", out_rd, 0);
        chk("midrst_out_val", out_val, 0);
        chk("midrst_out_rs2_val", out_rs2_val, 0);
        chk("midrst_out_is_ld", out_is_ld, 0);
        chk("midrst_out_illegal", out_illegal, 0);
        chk("midrst_in_stall", in_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        push(5'd3, 32'd12, 32'd0, 0, 0);
        issue(4'd0, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'd7, 1, 0);
        tick();
        idle();
        chk("final_pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
